// File: rtl/debounce_pkg.sv
// Shared types and helpers for the debounce/strobe input conditioning stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package debounce_pkg;

    typedef enum logic {
        STABLE,
        COUNTING
    } db_state_t;

    // Width of a counter that must hold values 0..n. It is never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/debounce_strobe_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Latency: 2 clk edges from din to dout.
// Backpressure: none; samples every cycle.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset; loads RST_VAL into both stages
//   din  - asynchronous input
//   dout - synchronized output
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic s1_q, s1_d;
    logic s_q,  s_d;

    always_comb begin
        s1_d = din;
        s_d  = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RST_VAL;
            s_q  <= RST_VAL;
        end else begin
            s1_q <= s1_d;
            s_q  <= s_d;
        end
    end

    assign dout = s_q;

endmodule

// File: rtl/debounce_strobe.sv
// Synchronizes and debounces a raw input, then emits a one-cycle enable strobe with rise/fall on each accepted change.
// Latency: STABLE_CYCLES+2 edges from a din change to q_d/q_en when tick is held high.
// Backpressure: none; tick only qualifies which cycles count toward stability.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   din      - asynchronous raw input
//   tick     - sample qualifier (tie high to count every cycle)
//   q_d      - debounced level
//   q_en     - one-cycle strobe on each accepted change
//   rise     - coincident with q_en when the new level is 1
//   fall     - coincident with q_en when the new level is 0
module debounce_strobe
    import debounce_pkg::*;
#(
    parameter int   STABLE_CYCLES = 4,
    parameter logic RST_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic tick,
    output logic q_d,
    output logic q_en,
    output logic rise,
    output logic fall
);

    localparam int            CW   = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic s;

    sync_2ff #(
        .RST_VAL (RST_VAL)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (s)
    );

    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          level_q, level_d;
    logic          q_en_q,  q_en_d;
    logic          rise_q,  rise_d;
    logic          fall_q,  fall_d;
    logic          accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        q_en_d  = 1'b0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        accept  = 1'b0;

        case (state_q)
            STABLE: begin
                if (s != level_q) begin
                    state_d = COUNTING;
                    if (tick) begin
                        // With a single required sample, the first qualified mismatch is enough to accept.
                        if (STABLE_CYCLES == 1) begin
                            accept = 1'b1;
                        end else begin
                            cnt_d = CW'(1);
                        end
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            COUNTING: begin
                if (s == level_q) begin
                    // The input bounced back before it was qualified, so drop it without a strobe.
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == LAST) begin
                        accept = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            level_d = s;
            q_en_d  = 1'b1;
            rise_d  = s;
            fall_d  = ~s;
            cnt_d   = '0;
            state_d = STABLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            level_q <= RST_VAL;
            q_en_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            q_en_q  <= q_en_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q_d  = level_q;
    assign q_en = q_en_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: doc/debounce_strobe.md
# debounce_strobe

Input conditioning stage that feeds the downstream enable-qualified storage stage (data plus enable). It synchronizes an asynchronous 1-bit input and debounces it with a qualified-cycle counter. On each accepted level change it presents the new level on `q_d` and issues a one-cycle `q_en` strobe plus a rise/fall indication.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: number of consecutive qualified mismatching samples required to accept a change; legal range ≥1.
- `RST_VAL`, default 1'b0: value of `q_d` after reset.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `din`  input  1  asynchronous raw input.
- `tick`  input  1  sample qualifier; tie to 1 for per-cycle counting.
- `q_d`  output  1  debounced level; drives the downstream data input.
- `q_en`  output  1  one-cycle strobe on an accepted change; drives the downstream enable input.
- `rise`  output  1  one-cycle pulse, coincident with `q_en`, when the accepted level is 1.
- `fall`  output  1  one-cycle pulse, coincident with `q_en`, when the accepted level is 0.

## Operation
- Synchronizer: 2-flop chain `din`→`s1`→`s`. It runs every cycle and ignores `tick`.
- FSM states are STABLE and COUNTING. Counter `cnt` has width $clog2(STABLE_CYCLES+1).
- STABLE, with `s == q_d`: hold, `cnt = 0`.
- STABLE, with `s != q_d`:
  - If `tick`=1, `cnt` becomes 1. If STABLE_CYCLES==1, accept immediately instead.
  - Move to COUNTING.
- COUNTING, with `s == q_d`: return to STABLE, `cnt = 0`, no strobe (glitch rejected).
- COUNTING, with `s != q_d` and `tick`=1:
  - If `cnt == STABLE_CYCLES-1`, accept.
  - Otherwise increment `cnt`.
- COUNTING, with `s != q_d` and `tick`=0: hold `cnt`.
- Accept means, on the same edge:
  - `q_d <= s`.
  - `q_en <= 1`.
  - `rise <= s`, `fall <= ~s`.
  - `cnt <= 0`, state becomes STABLE.
- `q_en`, `rise` and `fall` are registered and are high for exactly one cycle per accept, then return to 0.
- `rise` and `fall` are never both high. Neither is high without `q_en`.
- `cnt` never exceeds STABLE_CYCLES-1, so no wrap-around is possible.

## Timing
- Reset values: `q_d`=RST_VAL, `q_en`=`rise`=`fall`=0, `s1`=`s`=RST_VAL, state STABLE, `cnt`=0.
- `rst` has priority over every other condition in the same cycle.
- Reset mid-count discards the pending change; no strobe is produced.
- Latency with `tick`=1 and `din` held: `q_d`/`q_en` update at the (STABLE_CYCLES+2)th rising edge after `din` changes, counting the first capture edge. That is 2 synchronizer edges plus STABLE_CYCLES qualified samples.
- With a sparse `tick`, latency is 2 edges, plus the edges needed to see STABLE_CYCLES ticks while the mismatch persists, with the last one being the accept edge.
- A `din` change back to the `q_d` value that reaches `s` on any cycle clears the count, whether or not `tick` is high.
- Back-to-back accepts are separated by at least STABLE_CYCLES qualified samples, so `q_en` is never high in two consecutive cycles when STABLE_CYCLES ≥2.
  - With STABLE_CYCLES=1, back-to-back accepts are allowed only if `s` toggles every cycle.
- No combinational path from any input to any output.

## Structure
- Package `debounce_pkg` holds:
  - `typedef enum logic {STABLE, COUNTING} db_state_t;`
  - The counter-width helper constant function.
- Sub-module `sync_2ff` contains the two-flop synchronizer with a `RST_VAL` parameter. It uses the same `clk`/`rst` and is reused elsewhere.
- Top level `debounce_strobe` contains the FSM, the counter and the output registers.

## Test plan
- Reset: assert `rst` with `din`=1, RST_VAL=0 → after the edge, `q_d`=0, `q_en`=`rise`=`fall`=0. `rst` wins over a simultaneous accept.
- Clean rise: STABLE_CYCLES=4, `tick`=1, `din` 0→1 and held → `q_d`=1 and `q_en`=`rise`=1 at edge 6; `q_en`=0 at edge 7.
- Glitch: `din` high for 3 cycles then low, STABLE_CYCLES=4 → no `q_en`, `q_d` stays 0, `cnt` returns to 0.
- Sparse tick: `tick` high every 3rd cycle, STABLE_CYCLES=2, `din` 1→0 held → single `q_en`/`fall` pulse on the 2nd tick edge after `s` changes.
- Reset mid-count: `rst` for 1 cycle while `cnt`=2 → no strobe. Counting restarts from 0 afterwards, and accept occurs STABLE_CYCLES qualified samples later.
- Edge case STABLE_CYCLES=1: `din` toggle → accept on the 3rd edge. Check `rise`/`fall` exclusivity under random `din`/`tick` for 10k cycles.
